// File: rtl/lib_rr_pkg.sv
// Shared definitions for the RR-interval meter: FSM state encoding and default sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lib_rr_pkg;

  // Measurement phases: waiting for a first edge, blanking after an edge, open measurement.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFRACT = 2'd1,
    COUNT   = 2'd2
  } rr_state_t;

  // Default counter width and tick thresholds.
  localparam int unsigned RR_CNT_W_DEF   = 16;
  localparam int unsigned RR_REFRACT_DEF = 72;
  localparam int unsigned RR_MAX_DEF     = 1080;

  // Depth of the interval history used by the averager.
  localparam int unsigned RR_AVG_DEPTH   = 4;

endpackage

// File: rtl/lib_rr_avg4.sv
// Running mean of the last four reported intervals (sum over CNT_W+2 bits, truncating /4).
// Latency: avg/avg_vld register on the same edge that registers the interval report.
// Backpressure: none; push/clear are single-cycle strobes that are always accepted.
module lib_rr_avg4
  import lib_rr_pkg::*;
#(
  parameter int unsigned CNT_W = RR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             clear,
  input  logic [CNT_W-1:0] sample,
  output logic [CNT_W-1:0] avg,
  output logic             avg_vld
);

  // hist[0] is the newest interval; hist[3] is the one that leaves the window on a push.
  logic [CNT_W-1:0] hist [RR_AVG_DEPTH];
  logic [CNT_W+1:0] sum_q;
  logic [CNT_W+1:0] sum_next;
  logic [2:0]       fill;
  logic [2:0]       fill_next;

  // Window sum after a push: add the newcomer, drop the oldest. Unfilled slots hold zero,
  // so the same expression works while the history is still filling.
  assign sum_next  = sum_q + {2'b00, sample} - {2'b00, hist[RR_AVG_DEPTH-1]};
  assign fill_next = (fill == 3'd4) ? fill : fill + 3'd1;

  // History shift, running sum, fill level and registered average output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RR_AVG_DEPTH; i++) hist[i] <= '0;
      sum_q   <= '0;
      fill    <= 3'd0;
      avg     <= '0;
      avg_vld <= 1'b0;
    end else begin
      avg_vld <= 1'b0;
      if (clear) begin
        // An abandoned measurement breaks the sequence; restart the window from empty.
        for (int i = 0; i < RR_AVG_DEPTH; i++) hist[i] <= '0;
        sum_q <= '0;
        fill  <= 3'd0;
      end else if (push) begin
        for (int i = RR_AVG_DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= sample;
        sum_q   <= sum_next;
        fill    <= fill_next;
        if (fill_next == 3'd4) begin
          avg     <= sum_next[CNT_W+1:2];
          avg_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lib_rr_interval_v1.sv
// Edge-to-edge interval meter in sample ticks with refractory blanking and timeout; optional
// 4-interval mean compiled in with macro LIB_RR_AVG_EN (otherwise avg_o/avg_vld_o read 0).
// Latency: interval/timeout/average pulses one cycle after the deciding input. Backpressure: none.
module lib_rr_interval_v1
  import lib_rr_pkg::*;
#(
  parameter int unsigned CNT_W         = RR_CNT_W_DEF,
  parameter int unsigned REFRACT_TICKS = RR_REFRACT_DEF,
  parameter int unsigned MAX_TICKS     = RR_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_i,
  input  logic             edge_i,
  output logic [CNT_W-1:0] interval_o,
  output logic             interval_vld_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] avg_o,
  output logic             avg_vld_o
);

  localparam logic [CNT_W-1:0] REFRACT_C = CNT_W'(REFRACT_TICKS);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_TICKS);
  localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};

  rr_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             expire;

  assign cnt_inc = cnt + ONE_C;

  // An edge during an open measurement closes it; it takes priority over a coincident timeout.
  assign accept = (state == COUNT) && edge_i;
  assign expire = (state == COUNT) && !edge_i && tick_i && (cnt_inc == MAX_C);

  // Measurement FSM with registered interval value and one-cycle report/timeout pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      interval_o     <= '0;
      interval_vld_o <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      interval_vld_o <= 1'b0;
      timeout_o      <= 1'b0;
      unique case (state)
        IDLE: begin
          // First edge only arms the meter; there is no previous edge to measure from.
          if (edge_i) begin
            cnt   <= '0;
            state <= REFRACT;
          end
        end
        REFRACT: begin
          if (tick_i) begin
            cnt <= cnt_inc;
            if (cnt_inc == REFRACT_C) state <= COUNT;
          end
        end
        COUNT: begin
          if (accept) begin
            // Report the count as it stood before any tick arriving with this edge.
            interval_o     <= cnt;
            interval_vld_o <= 1'b1;
            cnt            <= '0;
            state          <= REFRACT;
          end else if (expire) begin
            // Abandon the measurement; cnt is not advanced so it can never reach MAX or wrap.
            timeout_o <= 1'b1;
            state     <= IDLE;
          end else if (tick_i) begin
            cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LIB_RR_AVG_EN
  lib_rr_avg4 #(
    .CNT_W (CNT_W)
  ) u_avg4 (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .clear   (expire),
    .sample  (cnt),
    .avg     (avg_o),
    .avg_vld (avg_vld_o)
  );
`else
  assign avg_o     = '0;
  assign avg_vld_o = 1'b0;
`endif

endmodule

// File: tb/tb_lib_rr_interval_v1.sv
// Scoreboard bench for lib_rr_interval_v1: directed patterns plus random tick/edge traffic,
// checked against a tick-counting reference model; averager checks follow LIB_RR_AVG_EN.
module tb_lib_rr_interval_v1;

  localparam int CNT_W = 16;
  localparam int REFR  = 4;
  localparam int MAXT  = 20;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             tick_i;
  logic             edge_i;
  logic [CNT_W-1:0] interval_o;
  logic             interval_vld_o;
  logic             timeout_o;
  logic [CNT_W-1:0] avg_o;
  logic             avg_vld_o;

  lib_rr_interval_v1 #(
    .CNT_W         (CNT_W),
    .REFRACT_TICKS (REFR),
    .MAX_TICKS     (MAXT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .tick_i         (tick_i),
    .edge_i         (edge_i),
    .interval_o     (interval_o),
    .interval_vld_o (interval_vld_o),
    .timeout_o      (timeout_o),
    .avg_o          (avg_o),
    .avg_vld_o      (avg_vld_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    bit is_to;
    int val;
    bit avg_v;
    int avg;
  } exp_t;

  exp_t sb [$];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: "armed" means a previous edge was accepted; ticks counts the ticks seen
  // on the cycles after that edge. The first REFR ticks are blanking time.
  bit armed = 1'b0;
  int ticks = 0;
  int hist [$];

  task automatic model(input bit e, input bit t);
    exp_t x;
    int s;
    if (!armed) begin
      if (e) begin
        armed = 1'b1;
        ticks = 0;
      end
    end else if (ticks < REFR) begin
      if (t) ticks++;
    end else if (e) begin
      hist.push_back(ticks);
      if (hist.size() > 4) void'(hist.pop_front());
      s = 0;
      foreach (hist[i]) s += hist[i];
      x.due   = cyc + 1;
      x.is_to = 1'b0;
      x.val   = ticks;
      x.avg_v = (hist.size() == 4);
      x.avg   = s / 4;
      sb.push_back(x);
      ticks = 0;
    end else if (t) begin
      if (ticks + 1 == MAXT) begin
        armed = 1'b0;
        hist.delete();
        x.due   = cyc + 1;
        x.is_to = 1'b1;
        x.val   = 0;
        x.avg_v = 1'b0;
        x.avg   = 0;
        sb.push_back(x);
      end else begin
        ticks++;
      end
    end
  endtask

  task automatic step(input bit e, input bit t);
    @(negedge clk);
    edge_i = e;
    tick_i = t;
    model(e, t);
  endtask

  // Enough edge-free ticking cycles to force any open measurement into timeout.
  task automatic flush();
    for (int i = 0; i < MAXT + REFR + 4; i++) step(1'b0, 1'b1);
  endtask

  // n edges spaced gap cycles apart, ticks on every div-th cycle.
  task automatic run_pat(input int gap, input int n, input int div);
    int ph;
    ph = 0;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < gap; i++) begin
        step(i == 0, (ph % div) == 0);
        ph++;
      end
  endtask

  task automatic async_reset();
    @(negedge clk);
    edge_i = 1'b0;
    tick_i = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_interval_o", int'(interval_o), 0);
    chk("rst_interval_vld_o", int'(interval_vld_o), 0);
    chk("rst_timeout_o", int'(timeout_o), 0);
    chk("rst_avg_o", int'(avg_o), 0);
    chk("rst_avg_vld_o", int'(avg_vld_o), 0);
    armed = 1'b0;
    ticks = 0;
    hist.delete();
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT pulses and checks held outputs every cycle.
  int last_iv  = 0;
  int last_avg = 0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        last_iv  = 0;
        last_avg = 0;
      end
      chk("pulse_exclusive", int'(interval_vld_o & timeout_o), 0);
      if (interval_vld_o || timeout_o) begin
        chk("pulse_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pulse_cycle", cyc, e.due);
          chk("pulse_kind_timeout", int'(timeout_o), int'(e.is_to));
          if (!e.is_to) begin
            chk("interval_value", int'(interval_o), e.val);
            last_iv = e.val;
          end
`ifdef LIB_RR_AVG_EN
          chk("avg_vld_o", int'(avg_vld_o), int'(e.avg_v));
          if (e.avg_v) begin
            chk("avg_value", int'(avg_o), e.avg);
            last_avg = e.avg;
          end
`endif
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("pulse_missing", int'(interval_vld_o | timeout_o), 1);
      end
      chk("interval_hold", int'(interval_o), last_iv);
`ifdef LIB_RR_AVG_EN
      if (!interval_vld_o) chk("avg_vld_alone", int'(avg_vld_o), 0);
      chk("avg_hold", int'(avg_o), last_avg);
`else
      chk("avg_o_tied", int'(avg_o), 0);
      chk("avg_vld_o_tied", int'(avg_vld_o), 0);
`endif
    end
  end

  initial begin
    int gaps [5];
    reset_n = 1'b0;
    edge_i  = 1'b0;
    tick_i  = 1'b0;
    #1;
    chk("init_interval_o", int'(interval_o), 0);
    chk("init_timeout_o", int'(timeout_o), 0);
    chk("init_avg_o", int'(avg_o), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;

    // Two edges with continuous ticks.
    run_pat(11, 2, 1);
    flush();

    // Second edge lands inside the blanking window and must be ignored.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    flush();

    // Lone edge times out; the following edge only re-arms.
    step(1'b1, 1'b1);
    flush();
    step(1'b1, 1'b1);
    flush();

    // Half-rate ticks.
    run_pat(21, 2, 2);
    flush();

    // Averager sequence: intervals 8, 10, 12, 14, then 6.
    gaps = '{9, 11, 13, 15, 7};
    foreach (gaps[k]) begin
      step(1'b1, 1'b1);
      for (int i = 1; i < gaps[k]; i++) step(1'b0, 1'b1);
    end
    step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);

    // Reset in the middle of an open measurement; the next edge only arms.
    async_reset();
    run_pat(12, 3, 1);
    flush();

    // Random traffic, including edges coinciding with the timeout tick.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0);
    flush();
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
